wb_commit_unit: RTL and testbench

- Write-back stage consumer of the MEM/WB pipeline register outputs.
- Formats load data: byte/half extraction, sign/zero extension, LWL/LWR merge.
- Drives the GPR file write port.
- Owns the architectural HI/LO and LLbit state registers.
- Keeps a retired-instruction counter and a registered one-cycle-delayed debug trace of each commit.

---
 rtl/wb_commit_unit_if.sv | 47 ++++
 rtl/wb_commit_unit.sv | 152 +++++++++++++++
 tb/tb_wb_commit_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_unit_if.sv
// MEM/WB commit bundle: pipeline-register outputs in, GPR port and architectural state out.
interface wb_commit_unit_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NBYTE = 4;
  localparam int unsigned RADDR_W = 5;

  logic [XLEN-1:0]    wb_pc;
  logic [2:0]         wb_ldop;
  logic               wb_sel_mul;
  logic [XLEN-1:0]    wb_alures;
  logic [XLEN-1:0]    wb_mulres;
  logic [XLEN-1:0]    wb_m_vaddr;
  logic [XLEN-1:0]    wb_m_rdata;
  logic [NBYTE-1:0]   wb_wreg;
  logic [RADDR_W-1:0] wb_wraddr;
  logic               wb_hilo_wen;
  logic [2*XLEN-1:0]  wb_hilo;
  logic               wb_llb_wen;
  logic               wb_llbit;
  logic               llb_clr;

  logic [NBYTE-1:0]   rf_wen;
  logic [RADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]    rf_wdata;
  logic [XLEN-1:0]    hi;
  logic [XLEN-1:0]    lo;
  logic               llbit;
  logic [XLEN-1:0]    retire_cnt;
  logic [XLEN-1:0]    dbg_pc;
  logic [NBYTE-1:0]   dbg_wen;
  logic [RADDR_W-1:0] dbg_waddr;
  logic [XLEN-1:0]    dbg_wdata;

  modport master (
    output wb_pc, wb_ldop, wb_sel_mul, wb_alures, wb_mulres, wb_m_vaddr, wb_m_rdata,
           wb_wreg, wb_wraddr, wb_hilo_wen, wb_hilo, wb_llb_wen, wb_llbit, llb_clr,
    input  rf_wen, rf_waddr, rf_wdata, hi, lo, llbit, retire_cnt,
           dbg_pc, dbg_wen, dbg_waddr, dbg_wdata
  );

  modport slave (
    input  wb_pc, wb_ldop, wb_sel_mul, wb_alures, wb_mulres, wb_m_vaddr, wb_m_rdata,
           wb_wreg, wb_wraddr, wb_hilo_wen, wb_hilo, wb_llb_wen, wb_llbit, llb_clr,
    output rf_wen, rf_waddr, rf_wdata, hi, lo, llbit, retire_cnt,
           dbg_pc, dbg_wen, dbg_waddr, dbg_wdata
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Write-back commit: load data formatting, GPR write port, HI/LO, LLbit,
// retired-instruction counter and a one-cycle-delayed commit trace.
module wb_commit_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst,
  wb_commit_unit_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NBYTE = 4;
  localparam int unsigned RADDR_W = 5;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [2:0] LD_LWL  = 3'd6;
  localparam logic [2:0] LD_LWR  = 3'd7;

  logic [XLEN-1:0]    base;
  logic [XLEN-1:0]    mem;
  logic [1:0]         off;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [XLEN-1:0]    wdata;
  logic [NBYTE-1:0]   mask;
  logic [NBYTE-1:0]   wen;

  logic [XLEN-1:0]    hi_q;
  logic [XLEN-1:0]    lo_q;
  logic               llbit_q;
  logic [XLEN-1:0]    retire_q;
  logic [XLEN-1:0]    dbg_pc_q;
  logic [NBYTE-1:0]   dbg_wen_q;
  logic [RADDR_W-1:0] dbg_waddr_q;
  logic [XLEN-1:0]    dbg_wdata_q;

  // Only the byte offset of the load address matters here.
  logic unused_vaddr;
  assign unused_vaddr = ^bus.wb_m_vaddr[XLEN-1:2];

  assign base = bus.wb_sel_mul ? bus.wb_mulres : bus.wb_alures;
  assign mem  = bus.wb_m_rdata;
  assign off  = bus.wb_m_vaddr[1:0];

  // Byte and halfword lane selection from the aligned little-endian word.
  always_comb begin
    byte_sel = mem[7:0];
    case (off)
      2'd0:    byte_sel = mem[7:0];
      2'd1:    byte_sel = mem[15:8];
      2'd2:    byte_sel = mem[23:16];
      default: byte_sel = mem[31:24];
    endcase
    half_sel = off[1] ? mem[31:16] : mem[15:0];
  end

  // Load formatting and byte mask; LWL/LWR merge memory bytes into old rt (base).
  always_comb begin
    wdata = base;
    mask  = 4'b1111;
    case (bus.wb_ldop)
      LD_NONE: wdata = base;
      LD_LB:   wdata = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  wdata = {24'h0, byte_sel};
      LD_LH:   wdata = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  wdata = {16'h0, half_sel};
      LD_LW:   wdata = mem;
      LD_LWL: begin
        case (off)
          2'd0: begin wdata = {mem[7:0],  base[23:0]}; mask = 4'b1000; end
          2'd1: begin wdata = {mem[15:0], base[15:0]}; mask = 4'b1100; end
          2'd2: begin wdata = {mem[23:0], base[7:0]};  mask = 4'b1110; end
          default: begin wdata = mem;                  mask = 4'b1111; end
        endcase
      end
      default: begin
        case (off)
          2'd0: begin wdata = mem;                       mask = 4'b1111; end
          2'd1: begin wdata = {base[31:24], mem[31:8]};  mask = 4'b0111; end
          2'd2: begin wdata = {base[31:16], mem[31:16]}; mask = 4'b0011; end
          default: begin wdata = {base[31:8], mem[31:24]}; mask = 4'b0001; end
        endcase
      end
    endcase
  end

  // $zero is never written.
  assign wen = (bus.wb_wraddr == RADDR_W'(0)) ? NBYTE'(0) : (bus.wb_wreg & mask);

  assign bus.rf_wen   = wen;
  assign bus.rf_waddr = bus.wb_wraddr;
  assign bus.rf_wdata = wdata;

  // Architectural HI/LO; no bypass, new value visible the cycle after commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (bus.wb_hilo_wen) begin
      hi_q <= bus.wb_hilo[2*XLEN-1:XLEN];
      lo_q <= bus.wb_hilo[XLEN-1:0];
    end
  end

  // LLbit; a clear (ERET/exception) overrides a same-cycle write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      llbit_q <= 1'b0;
    end else if (bus.llb_clr) begin
      llbit_q <= 1'b0;
    end else if (bus.wb_llb_wen) begin
      llbit_q <= bus.wb_llbit;
    end
  end

  // Retired-instruction counter; bubbles carry RESET_PC and do not count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_q <= '0;
    end else if (bus.wb_pc != RESET_PC) begin
      retire_q <= retire_q + XLEN'(1);
    end
  end

  // Commit trace, latched every cycle including bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_pc_q    <= '0;
      dbg_wen_q   <= '0;
      dbg_waddr_q <= '0;
      dbg_wdata_q <= '0;
    end else begin
      dbg_pc_q    <= bus.wb_pc;
      dbg_wen_q   <= wen;
      dbg_waddr_q <= bus.wb_wraddr;
      dbg_wdata_q <= wdata;
    end
  end

  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.llbit      = llbit_q;
  assign bus.retire_cnt = retire_q;
  assign bus.dbg_pc     = dbg_pc_q;
  assign bus.dbg_wen    = dbg_wen_q;
  assign bus.dbg_waddr  = dbg_waddr_q;
  assign bus.dbg_wdata  = dbg_wdata_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
// Directed bench for wb_commit_unit with hand-computed expectations.
module tb_wb_commit_unit;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  wb_commit_unit_if bus();

  wb_commit_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_wb(input logic [31:0] pc, input logic [2:0] ldop, input logic sel_mul,
                          input logic [31:0] alu, input logic [31:0] mul,
                          input logic [31:0] vaddr, input logic [31:0] rdata,
                          input logic [3:0] wreg, input logic [4:0] waddr);
    bus.wb_pc      = pc;
    bus.wb_ldop    = ldop;
    bus.wb_sel_mul = sel_mul;
    bus.wb_alures  = alu;
    bus.wb_mulres  = mul;
    bus.wb_m_vaddr = vaddr;
    bus.wb_m_rdata = rdata;
    bus.wb_wreg    = wreg;
    bus.wb_wraddr  = waddr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    drive_wb(32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0);
    bus.wb_hilo_wen = 1'b0;
    bus.wb_hilo     = 64'h0;
    bus.wb_llb_wen  = 1'b0;
    bus.wb_llbit    = 1'b0;
    bus.llb_clr     = 1'b0;

    // 1: reset, release, idle
    #12;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("rst_hi", 64'(bus.hi), 64'h0);
    check("rst_lo", 64'(bus.lo), 64'h0);
    check("rst_llbit", 64'(bus.llbit), 64'h0);
    check("rst_retire", 64'(bus.retire_cnt), 64'h0);
    check("rst_dbg_pc", 64'(bus.dbg_pc), 64'h0);
    check("rst_rf_wen", 64'(bus.rf_wen), 64'h0);

    // 2: byte/half extraction, mem = 80FF_7F01
    drive_wb(32'h0, 3'd1, 1'b0, 32'h0, 32'h0, 32'h2, 32'h80FF_7F01, 4'hF, 5'd7);
    #1 check("lb_o2", 64'(bus.rf_wdata), 64'hFFFF_FFFF);
    bus.wb_ldop = 3'd2; bus.wb_m_vaddr = 32'h1234_5673;
    #1 check("lbu_o3", 64'(bus.rf_wdata), 64'h0000_0080);
    bus.wb_ldop = 3'd3; bus.wb_m_vaddr = 32'h1;
    #1 check("lh_o1", 64'(bus.rf_wdata), 64'h0000_7F01);
    bus.wb_ldop = 3'd4; bus.wb_m_vaddr = 32'h2;
    #1 check("lhu_o2", 64'(bus.rf_wdata), 64'h0000_80FF);
    bus.wb_ldop = 3'd3;
    #1 check("lh_o2", 64'(bus.rf_wdata), 64'hFFFF_80FF);
    bus.wb_ldop = 3'd5; bus.wb_m_vaddr = 32'h3;
    #1 check("lw", 64'(bus.rf_wdata), 64'h80FF_7F01);
    check("lw_wen", 64'(bus.rf_wen), 64'hF);
    check("lw_waddr", 64'(bus.rf_waddr), 64'd7);

    // non-load base select
    drive_wb(32'h0, 3'd0, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 4'hF, 5'd9);
    #1 check("sel_mul", 64'(bus.rf_wdata), 64'h2222_2222);
    bus.wb_sel_mul = 1'b0;
    #1 check("sel_alu", 64'(bus.rf_wdata), 64'h1111_1111);

    // 3: LWL/LWR, B = AABB_CCDD, mem = 1122_3344
    drive_wb(32'h0, 3'd6, 1'b0, 32'hAABB_CCDD, 32'h0, 32'h1, 32'h1122_3344, 4'hF, 5'd4);
    #1 check("lwl_o1", 64'(bus.rf_wdata), 64'h3344_CCDD);
    check("lwl_o1_wen", 64'(bus.rf_wen), 64'b1100);
    bus.wb_m_vaddr = 32'h0;
    #1 check("lwl_o0", 64'(bus.rf_wdata), 64'h44BB_CCDD);
    check("lwl_o0_wen", 64'(bus.rf_wen), 64'b1000);
    bus.wb_ldop = 3'd7; bus.wb_m_vaddr = 32'h3;
    #1 check("lwr_o3", 64'(bus.rf_wdata), 64'hAABB_CC11);
    check("lwr_o3_wen", 64'(bus.rf_wen), 64'b0001);
    bus.wb_wreg = 4'b0110; bus.wb_m_vaddr = 32'h2;
    #1 check("lwr_o2_partial_wen", 64'(bus.rf_wen), 64'b0010);
    bus.wb_wreg = 4'hF;
    #1 check("lwr_o2", 64'(bus.rf_wdata), 64'hAABB_1122);
    check("lwr_o2_wen", 64'(bus.rf_wen), 64'b0011);
    step();
    check("dbg_wdata_lwr", 64'(bus.dbg_wdata), 64'hAABB_1122);
    check("dbg_wen_lwr", 64'(bus.dbg_wen), 64'b0011);
    check("dbg_waddr_lwr", 64'(bus.dbg_waddr), 64'd4);
    check("bubble_no_retire", 64'(bus.retire_cnt), 64'h0);
    drive_wb(32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0);

    // 4: HI/LO write then hold
    bus.wb_hilo_wen = 1'b1;
    bus.wb_hilo     = 64'h0000_0001_FFFF_FFFE;
    #1 check("hi_no_bypass", 64'(bus.hi), 64'h0);
    step();
    check("hi_wr", 64'(bus.hi), 64'h1);
    check("lo_wr", 64'(bus.lo), 64'hFFFF_FFFE);
    bus.wb_hilo_wen = 1'b0;
    bus.wb_hilo     = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    step();
    check("hi_hold", 64'(bus.hi), 64'h1);
    check("lo_hold", 64'(bus.lo), 64'hFFFF_FFFE);

    // 5: LLbit
    bus.wb_llb_wen = 1'b1; bus.wb_llbit = 1'b1;
    step();
    check("llbit_set", 64'(bus.llbit), 64'h1);
    bus.llb_clr = 1'b1;
    step();
    check("llbit_clr_wins", 64'(bus.llbit), 64'h0);
    bus.llb_clr = 1'b0;
    step();
    check("llbit_reset_again", 64'(bus.llbit), 64'h1);
    bus.wb_llb_wen = 1'b0; bus.wb_llbit = 1'b0;
    step();
    check("llbit_hold", 64'(bus.llbit), 64'h1);
    #2 rst = 1'b1;
    #1 check("async_rst_llbit", 64'(bus.llbit), 64'h0);
    check("async_rst_hi", 64'(bus.hi), 64'h0);
    #1 rst = 1'b0;

    // 6: commit stream 0x100, bubble, 0x104, 0x108 to $zero
    @(negedge clk);
    drive_wb(32'h100, 3'd0, 1'b0, 32'h0000_DEAD, 32'h0, 32'h0, 32'h0, 4'hF, 5'd3);
    step();
    check("dbg_pc_100", 64'(bus.dbg_pc), 64'h100);
    check("dbg_wdata_100", 64'(bus.dbg_wdata), 64'h0000_DEAD);
    check("retire_1", 64'(bus.retire_cnt), 64'd1);
    drive_wb(32'h0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0);
    step();
    check("dbg_pc_bubble", 64'(bus.dbg_pc), 64'h0);
    check("dbg_wen_bubble", 64'(bus.dbg_wen), 64'h0);
    check("retire_bubble", 64'(bus.retire_cnt), 64'd1);
    drive_wb(32'h104, 3'd0, 1'b0, 32'h5, 32'h0, 32'h0, 32'h0, 4'hF, 5'd5);
    step();
    check("dbg_pc_104", 64'(bus.dbg_pc), 64'h104);
    check("retire_2", 64'(bus.retire_cnt), 64'd2);
    drive_wb(32'h108, 3'd0, 1'b0, 32'h9, 32'h0, 32'h0, 32'h0, 4'hF, 5'd0);
    #1 check("zero_reg_wen", 64'(bus.rf_wen), 64'h0);
    step();
    check("dbg_pc_108", 64'(bus.dbg_pc), 64'h108);
    check("dbg_wen_108", 64'(bus.dbg_wen), 64'h0);
    check("retire_3", 64'(bus.retire_cnt), 64'd3);

    // counter wrap
    force dut.retire_q = 32'hFFFF_FFFF;
    #1 release dut.retire_q;
    #1 check("retire_preload", 64'(bus.retire_cnt), 64'hFFFF_FFFF);
    step();
    check("retire_wrap", 64'(bus.retire_cnt), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
